// File: rtl/add_arbiter.sv
// add_arbiter: two requesters share one 8-bit adder through an IDLE -> EXEC -> RESP handshake.
// Define ADD_ARBITER_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

// Shared 8-bit adder with carry out.
module add8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] out,
   output logic       cout
);
   assign {cout, out} = 9'(a) + 9'(b);
endmodule

module add_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   output logic       req1_ready,
   output logic       res_valid,
   output logic [7:0] res_sum,
   output logic       res_cout,
   output logic       res_id,
   input  logic       res_ready
);
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              id;
   } operand_t;

   state_t            state;
   operand_t          opnd;
   logic              last_grant;
   logic              grant_id;
   logic              accept;
   logic [DATA_W-1:0] add_out;
   logic              add_cout;

   add8 u_add8 (
      .a    (opnd.a),
      .b    (opnd.b),
      .out  (add_out),
      .cout (add_cout)
   );

   // Grant selection; ready is combinational so the requester sees it in the accept cycle.
   always_comb begin
      grant_id = 1'b0;
      if (req0_valid && req1_valid) begin
`ifdef ADD_ARBITER_RR_EN
         grant_id = ~last_grant;
`else
         grant_id = 1'b0;
`endif
      end else if (req1_valid) begin
         grant_id = 1'b1;
      end
      accept     = (state == S_IDLE) && !rst && (req0_valid || req1_valid);
      req0_ready = accept && !grant_id;
      req1_ready = accept &&  grant_id;
   end

`ifndef ADD_ARBITER_RR_EN
   // Fixed priority keeps last_grant only for observability.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         opnd       <= '0;
         last_grant <= 1'b1;
         res_valid  <= 1'b0;
         res_sum    <= '0;
         res_cout   <= 1'b0;
         res_id     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  opnd.a     <= grant_id ? req1_a : req0_a;
                  opnd.b     <= grant_id ? req1_b : req0_b;
                  opnd.id    <= grant_id;
                  last_grant <= grant_id;
                  state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               res_sum   <= add_out;
               res_cout  <= add_cout;
               res_id    <= opnd.id;
               res_valid <= 1'b1;
               state     <= S_RESP;
            end
            S_RESP: begin
               // Result held until the consumer takes it.
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: requester drivers, result monitor and a policy-level model.
// Honors ADD_ARBITER_RR_EN the same way as the design.
`timescale 1ns/1ps
module tb_add_arbiter;
`ifdef ADD_ARBITER_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid, req1_valid, req0_ready, req1_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic       res_valid, res_cout, res_id, res_ready;
   logic [7:0] res_sum;

   add_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .res_valid(res_valid), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
      .res_ready(res_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [7:0] a; logic [7:0] b;} pair_t;
   typedef struct packed {logic [8:0] total; logic id;} exp_t;

   pair_t pend0[$], pend1[$];
   exp_t  sb[$];
   int    grant_log[$];
   int    checks = 0, passes = 0;
   int    cyc = 0, acc_cyc = 0;
   int    pushed[2], completed[2];
   logic  took0 = 1'b0, took1 = 1'b0;
   bit    rand_ready_en = 1'b0;
   bit    busy = 1'b0;
   logic  model_last = 1'b1;
   logic  pv = 1'b0, pr = 1'b0, pc = 1'b0, pid = 1'b0;
   logic [7:0] ps = '0;
   logic [7:0] last_sum = '0;
   logic  last_cout = 1'b0, last_id = 1'b0;
   exp_t  mon_e;
   logic  mon_g, mon_mg;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   // Policy reference: simultaneous requests go to req0 (fixed) or the one not granted last (RR).
   function automatic logic model_grant(input logic v0, input logic v1, input logic last);
      if (v0 && v1) return RR_EN && !last;
      return v1;
   endfunction

   always @(posedge clk) cyc++;

   // Requester drivers: hold valid and operands until ready was seen.
   initial begin
      pair_t p;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0;
      res_ready  = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (req0_valid && took0) req0_valid = 1'b0;
         if (req1_valid && took1) req1_valid = 1'b0;
         took0 = 1'b0; took1 = 1'b0;
         if (!req0_valid && pend0.size() != 0) begin
            p = pend0.pop_front(); req0_a = p.a; req0_b = p.b; req0_valid = 1'b1;
         end
         if (!req1_valid && pend1.size() != 0) begin
            p = pend1.pop_front(); req1_a = p.a; req1_b = p.b; req1_valid = 1'b1;
         end
         if (rand_ready_en) res_ready = ($urandom_range(3) != 0);
      end
   end

   // Monitor: checks grants against the model, results against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         chk(!req0_ready && !req1_ready, "ready_in_reset", int'({req1_ready, req0_ready}), 0);
         sb.delete(); busy = 1'b0; model_last = 1'b1; pv = 1'b0; pr = 1'b0;
      end else begin
         if (req0_ready || req1_ready) begin
            mon_g  = req1_ready;
            mon_mg = model_grant(req0_valid, req1_valid, model_last);
            chk(!(req0_ready && req1_ready), "ready_exclusive", int'({req1_ready, req0_ready}), 1);
            chk(!busy, "accept_while_busy", int'(busy), 0);
            chk(mon_g == mon_mg, "grant_policy", int'(mon_g), int'(mon_mg));
            model_last = mon_g;
            grant_log.push_back(int'(mon_g));
            busy = 1'b1; acc_cyc = cyc;
            mon_e.total = mon_g ? (9'(req1_a) + 9'(req1_b)) : (9'(req0_a) + 9'(req0_b));
            mon_e.id    = mon_g;
            sb.push_back(mon_e);
            took0 = req0_ready; took1 = req1_ready;
         end
         if (res_valid) begin
            if (!pv || pr) begin
               chk(cyc - acc_cyc == 2, "latency", cyc - acc_cyc, 2);
               if (sb.size() == 0) chk(1'b0, "unexpected_result", int'(res_sum), -1);
               else begin
                  mon_e = sb[0];
                  chk(res_sum == mon_e.total[7:0], "sum", int'(res_sum), int'(mon_e.total[7:0]));
                  chk(res_cout == mon_e.total[8], "cout", int'(res_cout), int'(mon_e.total[8]));
                  chk(res_id == mon_e.id, "id", int'(res_id), int'(mon_e.id));
               end
            end else begin
               chk(res_sum == ps && res_cout == pc && res_id == pid, "hold_stable",
                   int'({res_id, res_cout, res_sum}), int'({pid, pc, ps}));
            end
            if (res_ready) begin
               if (sb.size() != 0) begin
                  mon_e = sb.pop_front();
                  completed[mon_e.id]++;
               end
               last_sum = res_sum; last_cout = res_cout; last_id = res_id;
               busy = 1'b0;
            end
         end
         pv = res_valid; pr = res_ready; ps = res_sum; pc = res_cout; pid = res_id;
      end
   end

   task automatic push(input int n, input logic [7:0] a, input logic [7:0] b, input bit count);
      pair_t p;
      p.a = a; p.b = b;
      if (n == 0) pend0.push_back(p); else pend1.push_back(p);
      if (count) pushed[n]++;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((pend0.size() != 0 || pend1.size() != 0 || req0_valid || req1_valid ||
              sb.size() != 0 || res_valid || busy) && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= budget) chk(1'b0, "drain_timeout", n, budget);
   endtask

   initial begin
      int exp_seq[4];
      int first;
      logic [8:0] bp_exp;
      void'($urandom(15));
      pushed[0] = 0; pushed[1] = 0; completed[0] = 0; completed[1] = 0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(res_valid == 1'b0, "rst_valid", int'(res_valid), 0);
      chk(res_sum == 8'h00, "rst_sum", int'(res_sum), 0);
      chk(res_cout == 1'b0, "rst_cout", int'(res_cout), 0);
      chk(res_id == 1'b0, "rst_id", int'(res_id), 0);

      // Single request, accepted in the first cycle after release
      push(0, 8'h12, 8'h34, 1'b1);
      @(posedge clk); #2; rst = 1'b0;
      @(negedge clk);
      chk(req0_ready == 1'b1, "first_cycle_idle", int'(req0_ready), 1);
      wait_drain(50);
      chk(last_sum == 8'h46 && last_cout == 1'b0 && last_id == 1'b0, "single_0x12_0x34",
          int'({last_id, last_cout, last_sum}), 'h046);

      // Overflow cases; req1 goes last so RR starts contention with req0
      push(0, 8'h80, 8'h80, 1'b1);
      wait_drain(50);
      chk(last_sum == 8'h00 && last_cout == 1'b1 && last_id == 1'b0, "ovf_0x80_0x80",
          int'({last_id, last_cout, last_sum}), 'h100);
      push(1, 8'hFF, 8'h01, 1'b1);
      wait_drain(50);
      chk(last_sum == 8'h00 && last_cout == 1'b1 && last_id == 1'b1, "ovf_0xff_0x01",
          int'({last_id, last_cout, last_sum}), 'h300);

      // Contention with both requesters continuously valid
      grant_log.delete();
      for (int i = 0; i < 4; i++) begin
         push(0, 8'($urandom), 8'($urandom), 1'b1);
         push(1, 8'($urandom), 8'($urandom), 1'b1);
      end
      wait_drain(300);
      if (RR_EN) exp_seq = '{0, 1, 0, 1};
      else       exp_seq = '{0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         first = (grant_log.size() > i) ? grant_log[i] : -1;
         chk(first == exp_seq[i], $sformatf("contention_grant%0d", i), first, exp_seq[i]);
      end

      // Backpressure for 5 cycles in RESP
      @(posedge clk); #2; res_ready = 1'b0;
      push(0, 8'h5A, 8'hC3, 1'b1);
      bp_exp = 9'h05A + 9'h0C3;
      for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
      chk(res_valid == 1'b1, "bp_result_present", int'(res_valid), 1);
      push(1, 8'h01, 8'h02, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk(res_valid && res_sum == bp_exp[7:0] && res_cout == bp_exp[8] && !req0_ready && !req1_ready,
             $sformatf("bp_hold%0d", i), int'({req1_ready, req0_ready, res_valid, res_cout, res_sum}),
             int'({3'b001, bp_exp}));
      end
      @(posedge clk); #2; res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk(res_valid == 1'b0 && req1_ready == 1'b1, "bp_release_idle",
          int'({req1_ready, res_valid}), 2);
      wait_drain(50);

      // Reset while in EXEC discards the transaction
      push(0, 8'h10, 8'h20, 1'b0);
      for (int i = 0; i < 20 && !req0_ready; i++) @(negedge clk);
      chk(req0_ready == 1'b1, "rst_exec_accept", int'(req0_ready), 1);
      @(posedge clk); #2; rst = 1'b1;
      @(negedge clk);
      chk(res_valid == 1'b0, "rst_exec_no_valid", int'(res_valid), 0);
      @(negedge clk);
      chk(res_valid == 1'b0 && res_sum == 8'h00 && res_cout == 1'b0 && res_id == 1'b0,
          "rst_exec_outputs_zero", int'({res_id, res_cout, res_valid, res_sum}), 0);
      grant_log.delete();
      push(0, 8'h07, 8'h09, 1'b1);
      push(1, 8'h0B, 8'h0D, 1'b1);
      @(posedge clk); #2; rst = 1'b0;
      wait_drain(100);
      first = (grant_log.size() > 0) ? grant_log[0] : -1;
      chk(first == 0, "post_rst_first_grant", first, 0);

      // Randomised traffic with random consumer backpressure
      rand_ready_en = 1'b1;
      for (int i = 0; i < 60; i++)
         push(int'($urandom_range(1)), 8'($urandom), 8'($urandom), 1'b1);
      wait_drain(3000);
      rand_ready_en = 1'b0;
      @(posedge clk); #2; res_ready = 1'b1;
      wait_drain(50);

      chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
      chk(completed[0] == pushed[0], "req0_complete_count", completed[0], pushed[0]);
      chk(completed[1] == pushed[1], "req1_complete_count", completed[1], pushed[1]);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Ports SHALL be listed as name, direction, width, meaning, with clock and reset first.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-006 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  same widths/meaning for requester 1.
REQ-008 res_valid  output  1  result held and valid.
REQ-009 res_sum  output  8  sum of granted operands, modulo 256.
REQ-010 res_cout  output  1  carry out of the 8-bit add.
REQ-011 res_id  output  1  requester that owns the result (0 or 1).
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 The block SHALL instantiate the team's existing 8-bit adder (ports a, b, out, cout) as the single shared arithmetic resource.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP.
REQ-015 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally in that cycle, latch its a/b and id into operand registers, go to EXEC; otherwise stay.
REQ-016 reqN_ready SHALL be high only in IDLE, only for the granted requester; never both high.
REQ-017 EXEC: adder driven from operand registers; sum and cout registered into res_sum/res_cout, res_id from latched id; go to RESP.
REQ-018 RESP: res_valid high; res_sum/res_cout/res_id stable while res_valid=1 and res_ready=0.
REQ-019 RESP with res_ready=1: res_valid deasserts next cycle, FSM to IDLE.
REQ-020 Latency: accept at edge N -> res_valid high after edge N+2; minimum three cycles per transaction; no new accept while in EXEC or RESP.
REQ-021 Arithmetic: res_sum = (a+b)[7:0], res_cout = (a+b)[8]; e.g. 0xFF+0x01 -> sum 0x00, cout 1.
REQ-022 A requester SHALL hold valid and operands until its ready; the block samples operands only in the ready cycle.
REQ-023 Arbitration policy per REQ-028/REQ-029; a single valid requester SHALL always be granted regardless of policy.
REQ-024 last_grant register updates on every accept to the granted id.

Reset
REQ-025 rst=1 at a rising edge SHALL force state IDLE, res_valid=0, res_sum=0x00, res_cout=0, res_id=0, operand registers 0, last_grant=1.
REQ-026 Reset mid-transaction (EXEC or RESP) SHALL discard the transaction without emitting a result; reqN_ready SHALL be 0 while rst=1.
REQ-027 First cycle after reset release SHALL behave as IDLE.

Configuration
REQ-028 With ADD_ARBITER_RR_EN defined: round-robin; on simultaneous valids grant the requester not equal to last_grant (req0 first after reset).
REQ-029 Without ADD_ARBITER_RR_EN: fixed priority; on simultaneous valids requester 0 always wins; last_grant still tracked but unused for decisions.

Verification
REQ-030 Single request: req0 a=0x12 b=0x34, res_ready=1 -> res_valid 2 cycles after accept, sum=0x46, cout=0, id=0.
REQ-031 Overflow: req1 a=0xFF b=0x01 -> sum=0x00, cout=1, id=1; a=0x80 b=0x80 -> sum=0x00, cout=1.
REQ-032 Contention, RR_EN defined: both valid continuously, res_ready=1 -> grants 0,1,0,1; without macro -> 0,0,0,0 and req1 never ready.
REQ-033 Backpressure: res_ready=0 for 5 cycles in RESP -> res_valid and result stable, no reqN_ready; on res_ready=1 -> IDLE next cycle.
REQ-034 Reset in EXEC with req0 a=0x10 b=0x20 -> no res_valid, all outputs zero, next accept grants req0 first.
REQ-035 Randomised seeded operand pairs (seed 15) on both requesters -> every result equals reference a+b, ids match, no lost or duplicated transaction.
